lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_tcount.sv | 26 ++
 rtl/lcd_reader.sv | 168 ++++++++++++++++
 tb/tb_lcd_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD reader and writer blocks:
// FSM encoding, bus timing defaults and the writer's command bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EHI,
        ELO,
        DONE
    } lcd_state_t;

    // Phase timing defaults in 100 MHz clock cycles
    localparam int T_AS_DEF     = 8;
    localparam int T_EH_DEF     = 50;
    localparam int T_EL_DEF     = 60;
    localparam int POLL_MAX_DEF = 1023;

    localparam int TCW   = 16;
    localparam int CNT_W = 10;

    // Instruction bytes issued by the companion writer
    localparam logic [7:0] CMD_CLEAR       = 8'h01;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC   = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'h0C;
    localparam logic [7:0] CMD_FUNC_4BIT   = 8'h28;
    localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;

endpackage

// File: rtl/lcd_tcount.sv
// Loadable down-counter that parks at zero; the zero flag ends each bus phase.
module lcd_tcount #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// 4-bit LCD bus reader: two E pulses per byte, with optional busy-flag polling
// that repeats status reads until BF clears or the poll budget runs out.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = T_AS_DEF,
    parameter int T_EH     = T_EH_DEF,
    parameter int T_EL     = T_EL_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    output logic       busy,
    output logic       ack,
    output logic [7:0] dout,
    output logic       err,
    output logic       lcd_rs_,
    output logic       lcd_rw_,
    output logic       lcd_e_,
    input  logic [7:4] lcd_dat_i,
    output logic       lcd_dat_t
);

    // ELO is loaded with T_EL (not T_EL-1): the extra cycle is the per-nibble turnaround
    localparam logic [TCW-1:0]   LD_AS    = TCW'(T_AS - 1);
    localparam logic [TCW-1:0]   LD_EH    = TCW'(T_EH - 1);
    localparam logic [TCW-1:0]   LD_EL    = TCW'(T_EL);
    localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX - 1);

    lcd_state_t       state, state_next;
    logic             nib_lo, nib_lo_next;
    logic             rs_lat, poll_lat;
    logic [CNT_W-1:0] read_cnt;

    logic             tc_load, tc_zero;
    logic [TCW-1:0]   tc_val;
    logic             accept, sample, cnt_inc, set_err;
    logic             pad_active, rs_next;

    lcd_tcount #(.W(TCW)) u_tcount (
        .clk      (clk),
        .rst      (rst),
        .load     (tc_load),
        .load_val (tc_val),
        .zero     (tc_zero)
    );

    always_comb begin
        state_next  = state;
        nib_lo_next = nib_lo;
        tc_load     = 1'b0;
        tc_val      = '0;
        accept      = 1'b0;
        sample      = 1'b0;
        cnt_inc     = 1'b0;
        set_err     = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    accept      = 1'b1;
                    nib_lo_next = 1'b0;
                    state_next  = SETUP;
                    tc_load     = 1'b1;
                    tc_val      = LD_AS;
                end
            end
            SETUP: begin
                if (tc_zero) begin
                    state_next = EHI;
                    tc_load    = 1'b1;
                    tc_val     = LD_EH;
                end
            end
            EHI: begin
                if (tc_zero) begin
                    sample     = 1'b1;
                    state_next = ELO;
                    tc_load    = 1'b1;
                    tc_val     = LD_EL;
                end
            end
            ELO: begin
                // dout[7] already holds this read's BF from the high nibble
                if (tc_zero) begin
                    if (!nib_lo) begin
                        nib_lo_next = 1'b1;
                        state_next  = SETUP;
                        tc_load     = 1'b1;
                        tc_val      = LD_AS;
                    end else if (poll_lat && dout[7] && (read_cnt < POLL_LIM)) begin
                        cnt_inc     = 1'b1;
                        nib_lo_next = 1'b0;
                        state_next  = SETUP;
                        tc_load     = 1'b1;
                        tc_val      = LD_AS;
                    end else begin
                        set_err    = poll_lat & dout[7];
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pad_active = (state_next == SETUP) || (state_next == EHI) || (state_next == ELO);
        rs_next    = accept ? rs_sel : rs_lat;
    end

    // Pad and handshake outputs are registered from the next state so they change cleanly on the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            nib_lo   <= 1'b0;
            rs_lat   <= 1'b0;
            poll_lat <= 1'b0;
            read_cnt <= '0;
            dout     <= 8'h00;
            err      <= 1'b0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            lcd_e_   <= 1'b0;
            lcd_rw_  <= 1'b0;
            lcd_rs_  <= 1'b0;
        end else begin
            state  <= state_next;
            nib_lo <= nib_lo_next;

            if (accept) begin
                rs_lat   <= rs_sel;
                poll_lat <= poll & ~rs_sel;
                read_cnt <= '0;
                err      <= 1'b0;
            end else if (cnt_inc) begin
                read_cnt <= read_cnt + CNT_W'(1);
            end

            if (set_err) begin
                err <= 1'b1;
            end

            if (sample) begin
                if (nib_lo) begin
                    dout[3:0] <= lcd_dat_i;
                end else begin
                    dout[7:4] <= lcd_dat_i;
                end
            end

            busy    <= (state_next != IDLE);
            ack     <= (state_next == DONE);
            lcd_e_  <= (state_next == EHI);
            lcd_rw_ <= pad_active;
            lcd_rs_ <= pad_active & rs_next;
        end
    end

    assign lcd_dat_t = 1'b1;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: an LCD nibble model answers E pulses and
// a scoreboard queue holds the expected byte, error flag and ack latency.
module tb_lcd_reader;

    localparam int T_READ = 238;
    localparam int POLL_N = 4;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       rs_sel = 1'b0;
    logic       poll = 1'b0;
    logic       busy, ack, err, lcd_rs_, lcd_rw_, lcd_e_, lcd_dat_t;
    logic [7:0] dout;
    logic [7:4] lcd_dat_i;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt = 0;

    logic [7:0] resp_tab [0:15];
    int         e_rises = 0;
    int         e_base = 0;
    int         rd_idx;
    logic       e_prev = 1'b0;
    logic [7:0] cur_b;
    int         e_run = 0, e_pulses = 0, e_badw = 0, e_rw_bad = 0, rs_low = 0;

    always #5 clk = ~clk;

    lcd_reader #(
        .T_AS(8), .T_EH(50), .T_EL(60), .POLL_MAX(POLL_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rs_sel    (rs_sel),
        .poll      (poll),
        .busy      (busy),
        .ack       (ack),
        .dout      (dout),
        .err       (err),
        .lcd_rs_   (lcd_rs_),
        .lcd_rw_   (lcd_rw_),
        .lcd_e_    (lcd_e_),
        .lcd_dat_i (lcd_dat_i),
        .lcd_dat_t (lcd_dat_t)
    );

    // LCD model: each E pulse presents the next nibble, high nibble first
    assign rd_idx    = e_rises - e_base - 1;
    assign cur_b     = resp_tab[rd_idx[4:1]];
    assign lcd_dat_i = rd_idx[0] ? cur_b[3:0] : cur_b[7:4];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        e_prev <= lcd_e_;
        if (lcd_e_ && !e_prev) e_rises <= e_rises + 1;
        if (lcd_e_ && !lcd_rw_) e_rw_bad <= e_rw_bad + 1;
        if (lcd_rw_ && !lcd_rs_) rs_low <= rs_low + 1;
        if (lcd_e_) begin
            e_run <= e_run + 1;
        end else if (e_run != 0) begin
            e_pulses <= e_pulses + 1;
            if (e_run != 50) e_badw <= e_badw + 1;
            e_run <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack) begin
            ack_cnt <= ack_cnt + 1;
            if (sb.size() == 0) begin
                checkOutput("spurious_ack", 1, 0);
            end else begin
                checkOutput("dout", dout, sb[0].d);
                checkOutput("err", err, sb[0].e);
                checkOutput("latency", cyc - sb[0].acc, sb[0].lat);
                void'(sb.pop_front());
            end
        end
    end

    task automatic loadResp(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        resp_tab[0] = b0;
        resp_tab[1] = b1;
        resp_tab[2] = b2;
        resp_tab[3] = b3;
        e_base      = e_rises;
    endtask

    task automatic applyStimulus(input logic rsel, input logic pl, input logic [7:0] exp_d,
                                 input logic exp_e, input int nreads);
        @(negedge clk);
        req    = 1'b1;
        rs_sel = rsel;
        poll   = pl;
        @(posedge clk);
        #1;
        req = 1'b0;
        sb.push_back('{exp_d, exp_e, nreads * T_READ, cyc});
        checkOutput("busy_on_accept", busy, 1);
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0, b0, r0, a0, n, acc;
        for (int i = 0; i < 16; i++) resp_tab[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_e", lcd_e_, 0);
        checkOutput("rst_rw", lcd_rw_, 0);
        checkOutput("rst_rs", lcd_rs_, 0);
        checkOutput("rst_dat_t", lcd_dat_t, 1);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dout", dout, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] status read");
        loadResp(8'h4A, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h4A, 1'b0, 1);
        waitDone("status", 300);
        @(posedge clk);
        #1;
        checkOutput("idle_after_status", busy, 0);

        $display("[TB] data read");
        p0 = e_pulses; b0 = e_badw; r0 = rs_low;
        loadResp(8'h41, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h41, 1'b0, 1);
        waitDone("data", 300);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("data_e_pulses", e_pulses - p0, 2);
        checkOutput("data_e_width", e_badw - b0, 0);
        checkOutput("data_rs_high", rs_low - r0, 0);

        $display("[TB] busy poll");
        loadResp(8'h80, 8'h9F, 8'hC3, 8'h05);
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 4);
        waitDone("poll", 1100);

        $display("[TB] poll timeout");
        loadResp(8'h80, 8'h80, 8'h80, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h80, 1'b1, POLL_N);
        waitDone("timeout", 1100);
        @(posedge clk);
        #1;
        checkOutput("idle_after_timeout", busy, 0);

        $display("[TB] data read ignores poll");
        loadResp(8'h80, 8'h9F, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0, 1);
        waitDone("data_poll", 300);

        $display("[TB] reset during EHI");
        loadResp(8'h5A, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0, 1);
        n = 0;
        while (!lcd_e_ && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("e_reached", lcd_e_, 1);
        a0  = ack_cnt;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput("rst_mid_e", lcd_e_, 0);
        checkOutput("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        checkOutput("rst_mid_no_ack", ack_cnt - a0, 0);
        loadResp(8'h3C, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0, 1);
        waitDone("after_reset", 300);

        $display("[TB] req while busy");
        loadResp(8'h77, 8'h00, 8'h00, 8'h00);
        a0 = ack_cnt;
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1);
        repeat (20) @(negedge clk);
        req    = 1'b1;
        rs_sel = 1'b0;
        @(negedge clk);
        req = 1'b0;
        waitDone("busy_req", 300);
        repeat (300) @(negedge clk);
        #1;
        checkOutput("busy_req_acks", ack_cnt - a0, 1);

        $display("[TB] req held through DONE");
        loadResp(8'h11, 8'h22, 8'h00, 8'h00);
        @(negedge clk);
        req    = 1'b1;
        rs_sel = 1'b1;
        poll   = 1'b0;
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{8'h11, 1'b0, T_READ, acc});
        sb.push_back('{8'h22, 1'b0, T_READ, acc + T_READ + 2});
        repeat (T_READ + 2) @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("held_busy", busy, 1);
        waitDone("held", 600);

        checkOutput("e_without_rw", e_rw_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
